// File: rtl/clk_div_ctrl.sv
// Runtime-programmable clock divider: produces a divided level and a per-period tick,
// with the ratio changed through a valid/ready handshake and applied only at a period boundary.
module clk_div_ctrl #(
    parameter int W           = 8,
    parameter int DEFAULT_DIV = 3
) (
    input  logic         clk_in,
    input  logic         rst,
    input  logic         en,
    input  logic         cfg_valid,
    input  logic [W-1:0] cfg_div,
    output logic         cfg_ready,
    output logic         cfg_err,
    output logic         div_out,
    output logic         tick,
    output logic [W-1:0] cur_div
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]   cur_div_q, cur_div_d;
    logic [W-1:0]   pend_div_q, pend_div_d;
    logic           div_out_q, div_out_d;
    logic           tick_q, tick_d;
    logic           err_q, err_d;

    logic           offer;
    logic           take;
    logic           wrap;
    logic [W-1:0]   cnt_nxt;
    logic [W-1:0]   neff;

    assign cfg_ready = (state_q != PEND);
    assign offer     = cfg_valid && cfg_ready;
    assign take      = offer && (cfg_div != '0);
    assign wrap      = (cnt_q == (cur_div_q - W'(1)));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cur_div_d  = cur_div_q;
        pend_div_d = pend_div_q;
        div_out_d  = div_out_q;
        tick_d     = tick_q;
        err_d      = offer && (cfg_div == '0);
        cnt_nxt    = wrap ? '0 : (cnt_q + W'(1));
        neff       = cur_div_q;

        case (state_q)
            IDLE: begin
                if (take) begin
                    cur_div_d = cfg_div;
                end
                cnt_d = '0;
                if (en) begin
                    // First edge of a run starts a fresh period with whatever ratio is now in effect
                    state_d   = RUN;
                    tick_d    = 1'b1;
                    div_out_d = ((take ? cfg_div : cur_div_q) == W'(1));
                end else begin
                    tick_d    = 1'b0;
                    div_out_d = 1'b0;
                end
            end
            default: begin
                if (!en) begin
                    // Stopping promotes any accepted ratio so it is never lost
                    state_d   = IDLE;
                    cnt_d     = '0;
                    div_out_d = 1'b0;
                    tick_d    = 1'b0;
                    if (state_q == PEND) begin
                        cur_div_d = pend_div_q;
                    end else if (take) begin
                        cur_div_d = cfg_div;
                    end
                end else begin
                    if ((state_q == PEND) && wrap) begin
                        cur_div_d = pend_div_q;
                        neff      = pend_div_q;
                        state_d   = RUN;
                    end
                    if ((state_q == RUN) && take) begin
                        pend_div_d = cfg_div;
                        state_d    = PEND;
                    end
                    cnt_d     = cnt_nxt;
                    tick_d    = (cnt_nxt == '0);
                    div_out_d = (neff == W'(1)) || (cnt_nxt >= (neff - (neff >> 1)));
                end
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cur_div_q  <= W'(DEFAULT_DIV);
            pend_div_q <= W'(DEFAULT_DIV);
            div_out_q  <= 1'b0;
            tick_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_div_q  <= cur_div_d;
            pend_div_q <= pend_div_d;
            div_out_q  <= div_out_d;
            tick_q     <= tick_d;
            err_q      <= err_d;
        end
    end

    assign cfg_err = err_q;
    assign div_out = div_out_q;
    assign tick    = tick_q;
    assign cur_div = cur_div_q;

endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Runtime-programmable clock-divider controller for the clocking block. It produces a divided clock-level output and a per-period tick from `clk_in`, with the divide ratio reconfigurable through a valid/ready handshake. A new ratio is applied only at a period boundary, so the output never shows a runt pulse. It sits between the configuration logic and the fixed dividers, and replaces hard-wired ratios where software selects the rate.

## Interface
- `W`, 8: width of the divide ratio.
- `DEFAULT_DIV`, 3: ratio loaded at reset; must be 1..2^W-1.

- `clk_in` in 1: sole clock; all state updates on posedge.
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: run enable; level-sensitive.
- `cfg_valid` in 1: new ratio offered.
- `cfg_div` in W: offered ratio N.
- `cfg_ready` out 1: controller can accept a ratio.
- `cfg_err` out 1: one-cycle pulse when an offered ratio of 0 is rejected.
- `div_out` out 1: divided output, registered.
- `tick` out 1: one-cycle pulse in the first cycle of each output period, registered.
- `cur_div` out W: ratio currently in effect.

## Operation
- States:
  - IDLE: `en`=0 sampled.
  - RUN: counting, no pending ratio.
  - PEND: counting, ratio accepted but not yet applied.
- Registers: `cnt[W-1:0]`, `cur_div`, `pend_div`, state, `div_out`, `tick`, `cfg_err`.
- Counter:
  - In RUN or PEND, `cnt` steps 0..cur_div-1, then wraps to 0. The wrap edge is when `cnt`==cur_div-1.
  - `div_out` is set to 1 iff the next `cnt` >= cur_div - (cur_div>>1). Example: N=3 gives low, low, high. N=4 gives low, low, high, high.
  - N=1: `div_out` is held 1 and `tick` is 1 every cycle while running.
- `tick` is registered to 1 on every edge where `cnt` becomes 0 while running. This includes the first edge after enable.
- Handshake:
  - `cfg_ready` = (state != PEND). It is a combinational decode of registered state.
  - A transfer occurs on an edge with `cfg_valid` && `cfg_ready`.
  - `cfg_div`==0 is rejected: no state change, `cfg_err`=1 for exactly one cycle.
- Applying a ratio:
  - Transfer in IDLE: `cur_div` <= `cfg_div` on the same edge; state stays IDLE.
  - Transfer in RUN: `pend_div` <= `cfg_div`; state goes to PEND.
  - In PEND, `cur_div` <= `pend_div` on the first wrap edge strictly after the transfer edge. `cnt` wraps to 0 and the next period uses the new ratio. State returns to RUN.
  - A transfer on a wrap edge therefore waits one full old period.
- Enable:
  - `en` 0->1 sampled at edge e: state goes to RUN, `cnt` <= 0, `tick` <= 1.
  - `en` 1->0 sampled: state goes to IDLE, `cnt` <= 0, `div_out` <= 0, `tick` <= 0.
  - If PEND when `en` drops, `cur_div` <= `pend_div` on that edge; the pending ratio is never lost.
- Simultaneous transfer and `en` drop: the transfer is treated as a RUN transfer, then promoted immediately by the `en` drop. Net effect: `cur_div` <= `cfg_div`.

## Timing
- Reset (async assert, any time):
  - `cnt`=0, `cur_div`=DEFAULT_DIV, state=IDLE.
  - `div_out`=0, `tick`=0, `cfg_err`=0, `cfg_ready`=1.
- Release is synchronous to the next posedge. A reset mid-period abandons the period and any pending ratio.
- Latencies:
  - `en`-to-`tick`: 1 cycle (the `tick` flop sets on the edge sampling `en`=1).
  - Config in IDLE: `cur_div` updates on the transfer edge.
  - Config in RUN: applied 1..N cycles after transfer, always exactly at a wrap.
  - `cfg_ready` falls the cycle after a RUN transfer. It rises the cycle after the applying wrap.
- Output period:
  - Exactly `cur_div` cycles between `tick` pulses, except across an applying wrap.
  - `div_out` high time = floor(N/2) cycles (N=1: constant high).
- No combinational path from `cfg_valid` to `cfg_ready`.

## Test plan
- Reset then `en`=1 with DEFAULT_DIV=3: `div_out` pattern 0,0,1 repeating; `tick` every 3 cycles; `cur_div`=3.
- In IDLE, offer 4: `cur_div`=4 on the transfer edge; after `en`, `div_out` 0,0,1,1 repeating and `tick` period 4.
- Running at N=5, offer 2 at `cnt`=1: `cfg_ready` low for the remaining cycles. The switch happens at the wrap; the next period is 2 cycles, with no runt on `div_out`.
- Running at N=3, offer 6 on a wrap edge: the old ratio runs one more full 3-cycle period, then the 6-cycle period begins.
- Offer 0 while running: `cfg_err` high 1 cycle, `cur_div` unchanged, `cfg_ready` stays 1.
- In PEND, drop `en`: `cur_div` takes the pending value and outputs go 0. Separately, assert `rst` mid-period: all outputs take reset values immediately, without a clock edge.
